// File: rtl/serial_add_sequencer.sv
// Drives a 1-bit serial adder to perform a full WIDTH-bit addition.
// Operands stream LSB-first; the final carry is read back in a dedicated cycle.
`timescale 1ns/1ps
module serial_add_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             ser_rst,
    output logic             ser_a,
    output logic             ser_b,
    input  logic             ser_sum
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, CARRY, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [CW-1:0]    cnt_reg;
    logic             last_bit;

    assign last_bit = (cnt_reg == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)  state_next = SHIFT;
            SHIFT:   if (last_bit)  state_next = CARRY;
            CARRY:                  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // The adder carry is held clear whenever no bits are in flight or reset is asserted.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        ser_rst   = 1'b1;
        ser_a     = 1'b0;
        ser_b     = 1'b0;
        case (state_reg)
            IDLE:  in_ready = rst_n;
            SHIFT: begin
                ser_rst = ~rst_n;
                ser_a   = a_reg[0];
                ser_b   = b_reg[0];
            end
            CARRY: ser_rst = ~rst_n;
            DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Each result bit is written only in the SHIFT cycle that presents its operand bits.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_acc
            assign acc_next[gi] = (state_reg == SHIFT && cnt_reg == CW'(gi)) ? ser_sum : acc_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            out_sum   <= '0;
            out_carry <= 1'b0;
        end else begin
            acc_reg <= acc_next;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg   <= in_a;
                        b_reg   <= in_b;
                        cnt_reg <= '0;
                    end
                end
                SHIFT: begin
                    a_reg <= a_reg >> 1;
                    b_reg <= b_reg >> 1;
                    if (!last_bit) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                CARRY: begin
                    out_sum   <= acc_reg;
                    out_carry <= ser_sum;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Bench for serial_add_sequencer with a behavioural serial adder and a result scoreboard.
`timescale 1ns/1ps
module tb_serial_add_sequencer;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic             ser_rst, ser_a, ser_b, ser_sum;

    serial_add_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .ser_rst   (ser_rst),
        .ser_a     (ser_a),
        .ser_b     (ser_b),
        .ser_sum   (ser_sum)
    );

    always #5 clk = ~clk;

    // Serial adder: combinational sum, carry register with synchronous active-high clear.
    logic carry_q = 1'b1;
    assign ser_sum = ser_a ^ ser_b ^ carry_q;
    always @(posedge clk) begin
        if (ser_rst) carry_q <= 1'b0;
        else         carry_q <= (ser_a & ser_b) | (ser_a & carry_q) | (ser_b & carry_q);
    end

    int           n_vec = 0;
    int           n_err = 0;
    int           n_push = 0;
    int           n_pop = 0;
    int           n_drop = 0;
    logic [WIDTH:0] sb_q[$];
    logic [WIDTH:0] exp_r;
    logic         rnd_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on accepted operands, pop and compare on delivered results.
    always @(negedge clk) begin
        if (!rst_n) begin
            n_drop += sb_q.size();
            sb_q.delete();
        end else begin
            if (in_valid && in_ready) begin
                sb_q.push_back({1'b0, in_a} + {1'b0, in_b});
                n_push++;
            end
            if (out_valid && out_ready) begin
                check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    exp_r = sb_q.pop_front();
                    n_pop++;
                    check("sb_result", 32'({out_carry, out_sum}), 32'(exp_r));
                    $display("txn %0d: sum=0x%02h carry=%0d (expected 0x%02h carry=%0d)",
                             n_pop, out_sum, out_carry, exp_r[WIDTH-1:0], exp_r[WIDTH]);
                end
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int i;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (i >= 100) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [WIDTH-1:0] es, input logic ec, input string tag);
        int n;
        logic [WIDTH-1:0] sa;
        send(a, b);
        n = 0;
        sa = '0;
        do begin
            @(negedge clk);
            n++;
            if (n <= WIDTH) sa[n-1] = ser_a;
        end while (!out_valid && n < 100);
        check({tag, "_latency"}, 32'(n), 32'(WIDTH + 2));
        check({tag, "_ser_a"}, 32'(sa), 32'(a));
        check({tag, "_sum"}, 32'(out_sum), 32'(es));
        check({tag, "_carry"}, 32'(out_carry), 32'(ec));
    endtask

    task automatic wait_valid();
        int i;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        if (i >= 100) check("valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int i;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_ser_rst", 32'(ser_rst), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_carry", 32'(out_carry), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Directed additions
        op(8'h35, 8'h4A, 8'h7F, 1'b0, "add_35_4a");
        op(8'hFF, 8'h01, 8'h00, 1'b1, "add_ff_01");
        op(8'hFF, 8'hFF, 8'hFE, 1'b1, "add_ff_ff");

        // Reset in the middle of an operation
        send(8'hFF, 8'h01);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_ser_rst", 32'(ser_rst), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_sum", 32'(out_sum), 32'd0);
        check("midrst_out_carry", 32'(out_carry), 32'd0);
        check("midrst_in_ready_idle", 32'(in_ready), 32'd1);
        op(8'h01, 8'h01, 8'h02, 1'b0, "add_01_01");

        // Backpressure
        @(posedge clk); #1;
        out_ready = 1'b0;
        op(8'h35, 8'h4A, 8'h7F, 1'b0, "bp_add");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_sum", 32'(out_sum), 32'h7F);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);

        // in_valid held high with operands changing during the operation
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_a = 8'h10;
        in_b = 8'h20;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (i >= 100) check("hold_accept_timeout", 32'd0, 32'd1);
        for (i = 1; i < 100; i++) begin
            @(posedge clk); #1;
            in_a = 8'($urandom);
            in_b = 8'($urandom);
            @(negedge clk);
            if (in_ready) break;
        end
        check("hold_accept_spacing", 32'(i), 32'(WIDTH + 3));
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid();
        @(posedge clk); #1;

        // Random back-to-back traffic with consumer stalls
        fork
            begin
                for (int t = 0; t < 20; t++) begin
                    send(8'($urandom), 8'($urandom));
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                end
                for (int w = 0; w < 1000 && sb_q.size() != 0; w++) @(negedge clk);
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("drain_empty", 32'(sb_q.size()), 32'd0);
        check("txn_count", 32'(n_pop), 32'(n_push - n_drop));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
